// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the counter-width helper.
package div_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // Bits needed to hold any value in 0..value-1.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/div_step.sv
// One shift-subtract step of the restoring divider: trial-subtract the divisor
// from the shifted partial remainder and keep the difference if it is non-negative.
module div_step #(
   parameter int SIZE = 16
) (
   input  logic [SIZE-1:0] p_i,
   input  logic            a_msb_i,
   input  logic [SIZE-1:0] d_i,
   output logic [SIZE-1:0] p_o,
   output logic            qbit_o
);

   logic [SIZE:0] t;

   // Because P < D always holds, bit SIZE of the difference is exactly the borrow.
   always_comb begin
      t      = {p_i, a_msb_i} - {1'b0, d_i};
      qbit_o = ~t[SIZE];
      p_o    = qbit_o ? t[SIZE-1:0] : {p_i[SIZE-2:0], a_msb_i};
   end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands; the default build is unsigned.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int SIZE = 16
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            iStart,
   input  logic [SIZE-1:0] iDividend,
   input  logic [SIZE-1:0] iDivisor,
   output logic            oBusy,
   output logic            oDone,
   output logic [SIZE-1:0] oQuotient,
   output logic [SIZE-1:0] oRemainder,
   output logic            oDivByZero
);

   localparam int CW = clog2(SIZE + 1);

   div_state_e      state_q, state_d;
   logic [SIZE-1:0] a_q, a_d, d_q, d_d, p_q, p_d;
   logic [SIZE-1:0] quo_q, quo_d, rem_q, rem_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            dbz_q, dbz_d;

   logic            accept, div_zero, step_qbit;
   logic [SIZE-1:0] step_p, a_shift;
   logic [SIZE-1:0] dividend_mag, divisor_mag, quo_fix, rem_fix, dbz_quo;

   assign accept   = iStart && (state_q == DIV_IDLE || state_q == DIV_DONE);
   assign div_zero = (iDivisor == '0);

   div_step #(.SIZE(SIZE)) u_step (
      .p_i    (p_q),
      .a_msb_i(a_q[SIZE-1]),
      .d_i    (d_q),
      .p_o    (step_p),
      .qbit_o (step_qbit)
   );

   assign a_shift = {a_q[SIZE-2:0], step_qbit};

`ifdef DIV_SIGNED_EN
   logic neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

   // The core divides magnitudes; signs are reapplied on the CALC->DONE edge.
   assign dividend_mag = iDividend[SIZE-1] ? -iDividend : iDividend;
   assign divisor_mag  = iDivisor[SIZE-1]  ? -iDivisor  : iDivisor;
   assign quo_fix      = neg_quo_q ? -a_shift : a_shift;
   assign rem_fix      = neg_rem_q ? -step_p  : step_p;
   assign dbz_quo      = iDividend[SIZE-1] ? SIZE'(1) : '1;
`else
   assign dividend_mag = iDividend;
   assign divisor_mag  = iDivisor;
   assign quo_fix      = a_shift;
   assign rem_fix      = step_p;
   assign dbz_quo      = '1;
`endif

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state_q <= DIV_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DIV_IDLE, DIV_DONE: begin
            if (accept)                  state_d = div_zero ? DIV_DONE : DIV_CALC;
            else if (state_q == DIV_DONE) state_d = DIV_IDLE;
         end
         DIV_CALC: if (cnt_q == CW'(1)) state_d = DIV_DONE;
         default:  state_d = DIV_IDLE;
      endcase
   end

   always_comb begin
      oBusy = (state_q == DIV_CALC);
      oDone = (state_q == DIV_DONE);
   end

   always_comb begin
      // NOTE: every _d starts from its _q so no path leaves it unassigned (no latch).
      a_d   = a_q;
      d_d   = d_q;
      p_d   = p_q;
      cnt_d = cnt_q;
      quo_d = quo_q;
      rem_d = rem_q;
      dbz_d = dbz_q;
`ifdef DIV_SIGNED_EN
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
`endif
      if (accept) begin
         if (div_zero) begin
            quo_d = dbz_quo;
            rem_d = iDividend;
            dbz_d = 1'b1;
         end else begin
            a_d   = dividend_mag;
            d_d   = divisor_mag;
            p_d   = '0;
            cnt_d = CW'(SIZE);
            quo_d = '0;
            rem_d = '0;
            dbz_d = 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_d = iDividend[SIZE-1] ^ iDivisor[SIZE-1];
            neg_rem_d = iDividend[SIZE-1];
`endif
         end
      end else if (state_q == DIV_CALC) begin
         a_d   = a_shift;
         p_d   = step_p;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            quo_d = quo_fix;
            rem_d = rem_fix;
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      // NOTE: state is written with <= so every flop samples pre-edge values.
      if (Reset) begin
         a_q   <= '0;
         d_q   <= '0;
         p_q   <= '0;
         cnt_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         dbz_q <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
`endif
      end else begin
         a_q   <= a_d;
         d_q   <= d_d;
         p_q   <= p_d;
         cnt_q <= cnt_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
         dbz_q <= dbz_d;
`ifdef DIV_SIGNED_EN
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
`endif
      end
   end

   assign oQuotient  = quo_q;
   assign oRemainder = rem_q;
   assign oDivByZero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed handshake/corner cases
// plus random operands against a plain-arithmetic reference (honours DIV_SIGNED_EN).
module tb_seq_restoring_divider;

   localparam int SIZE = 16;

   logic            Clock = 1'b0;
   logic            Reset = 1'b1;
   logic            iStart = 1'b0;
   logic [SIZE-1:0] iDividend = '0;
   logic [SIZE-1:0] iDivisor = '0;
   logic            oBusy, oDone, oDivByZero;
   logic [SIZE-1:0] oQuotient, oRemainder;

   int checks = 0;
   int failures = 0;

   always #5 Clock = ~Clock;

   seq_restoring_divider #(.SIZE(SIZE)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .iStart    (iStart),
      .iDividend (iDividend),
      .iDivisor  (iDivisor),
      .oBusy     (oBusy),
      .oDone     (oDone),
      .oQuotient (oQuotient),
      .oRemainder(oRemainder),
      .oDivByZero(oDivByZero)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: straight integer division from the operand rules.
   task automatic ref_div(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                          output logic [SIZE-1:0] q, output logic [SIZE-1:0] r,
                          output logic z);
`ifdef DIV_SIGNED_EN
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      if (sb == 0) begin
         q = (sa >= 0) ? '1 : SIZE'(1);
         r = a;
         z = 1'b1;
      end else begin
         q = SIZE'(sa / sb);
         r = SIZE'(sa % sb);
         z = 1'b0;
      end
`else
      if (b == '0) begin
         q = '1;
         r = a;
         z = 1'b1;
      end else begin
         q = a / b;
         r = a % b;
         z = 1'b0;
      end
`endif
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic start(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
      iDividend = a;
      iDivisor  = b;
      iStart    = 1'b1;
      @(negedge Clock);
      iStart    = 1'b0;
      iDividend = SIZE'($urandom);
      iDivisor  = SIZE'($urandom);
   endtask

   // lat = index of the negedge (1 = current) where oDone is seen; -1 on timeout.
   task automatic wait_done(output int lat, output int busy_n);
      lat    = -1;
      busy_n = 0;
      for (int i = 1; i <= 40; i++) begin
         if (oBusy) busy_n++;
         if (oDone) begin
            lat = i;
            return;
         end
         @(negedge Clock);
      end
   endtask

   task automatic check_result(input string tag, input logic [SIZE-1:0] q,
                               input logic [SIZE-1:0] r, input logic z);
      check({tag, "_quot"}, oQuotient, q);
      check({tag, "_rem"},  oRemainder, r);
      check({tag, "_dbz"},  oDivByZero, z);
   endtask

   logic [SIZE-1:0] t3_a [3] = '{16'hFFFF, 16'd5, 16'd0};
   logic [SIZE-1:0] t3_b [3] = '{16'd1,    16'd9, 16'd3};
   logic [SIZE-1:0] t3_q [3] = '{16'hFFFF, 16'd0, 16'd0};
   logic [SIZE-1:0] t3_r [3] = '{16'd0,    16'd5, 16'd0};

   initial begin
      int lat, busy_n;
      logic seen;
      logic [SIZE-1:0] ra, rb, eq, er;
      logic ez;

      #1;
      check("rst_busy", oBusy, 0);
      check("rst_done", oDone, 0);
      check_result("rst", '0, '0, 1'b0);
      @(negedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);

      // Basic unsigned divide and timing
      start(16'd100, 16'd7);
      wait_done(lat, busy_n);
      check("t1_latency", lat, 17);
      check("t1_busy_cycles", busy_n, 16);
      check_result("t1", 16'd14, 16'd2, 1'b0);
      @(negedge Clock);
      check("t1_done_pulse", oDone, 0);
      check("t1_quot_held", oQuotient, 16'd14);

      // Divide by zero
      start(16'h1234, 16'd0);
      wait_done(lat, busy_n);
      check("t2_latency", lat, 1);
      check("t2_busy_cycles", busy_n, 0);
      check_result("t2", 16'hFFFF, 16'h1234, 1'b1);
      @(negedge Clock);
      check("t2_done_pulse", oDone, 0);

      // Extremes
      for (int i = 0; i < 3; i++) begin
         start(t3_a[i], t3_b[i]);
         wait_done(lat, busy_n);
         check("t3_latency", lat, 17);
         check_result("t3", t3_q[i], t3_r[i], 1'b0);
         @(negedge Clock);
      end

      // iStart during CALC is ignored; restart accepted in the DONE cycle
      start(16'd1000, 16'd7);
      repeat (4) @(negedge Clock);
      iDividend = 16'd60000;
      iDivisor  = 16'd3;
      iStart    = 1'b1;
      @(negedge Clock);
      iStart    = 1'b0;
      wait_done(lat, busy_n);
      check("t4_latency_ignored", lat, 12);
      check_result("t4a", 16'd142, 16'd6, 1'b0);
      start(16'd1000, 16'd3);
      wait_done(lat, busy_n);
      check("t4_restart_latency", lat, 17);
      check_result("t4b", 16'd333, 16'd1, 1'b0);
      @(negedge Clock);

      // Reset mid-operation
      start(16'd40000, 16'd3);
      repeat (7) @(negedge Clock);
      Reset = 1'b1;
      #1;
      check("t5_busy", oBusy, 0);
      check("t5_done", oDone, 0);
      check_result("t5_rst", '0, '0, 1'b0);
      @(negedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge Clock);
         if (oDone || oBusy) seen = 1'b1;
      end
      check("t5_no_done_after_abort", seen, 0);
      start(16'd50, 16'd5);
      wait_done(lat, busy_n);
      check("t5_latency", lat, 17);
      check_result("t5", 16'd10, 16'd0, 1'b0);
      @(negedge Clock);

`ifdef DIV_SIGNED_EN
      start(16'hFFF9, 16'd2);
      wait_done(lat, busy_n);
      check_result("t6a", 16'hFFFD, 16'hFFFF, 1'b0);
      start(16'd7, 16'hFFFE);
      wait_done(lat, busy_n);
      check_result("t6b", 16'hFFFD, 16'd1, 1'b0);
      start(16'h8000, 16'hFFFF);
      wait_done(lat, busy_n);
      check_result("t6c", 16'h8000, 16'd0, 1'b0);
      start(16'h8000, 16'd0);
      wait_done(lat, busy_n);
      check_result("t6d", 16'd1, 16'h8000, 1'b1);
      @(negedge Clock);
`endif

      // Random operands against the reference
      for (int n = 0; n < 1000; n++) begin
         ra = SIZE'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? SIZE'($urandom_range(0, 15)) : SIZE'($urandom);
         ref_div(ra, rb, eq, er, ez);
         start(ra, rb);
         wait_done(lat, busy_n);
         check("rnd_latency", lat, (rb == '0) ? 1 : 17);
         check_result("rnd", eq, er, ez);
         if ($urandom_range(0, 1) == 0) @(negedge Clock);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
